read_stage_rr_arbiter_pipe: RTL and testbench
=============================================

# read_stage_rr_arbiter_pipe

Parametrised N-input round-robin arbiter for the lane read stage. It merges read requests from several sources (vs, groupIndex, readSource, instructionIndex) onto one read-port request channel. A registered output stage gives one cycle of latency at full throughput. Grant fairness uses a last-winner pointer that advances only on accepted transfers. It sits between the per-source read request queues and the VRF read port.

## Interface
- NUM_IN, 4, number of requesting sources (≥1; 1 degenerates to a registered pass-through)
- VS_W, 5, vs field width
- GRP_W, 4, groupIndex width
- SRC_W, 4, readSource width
- IDX_W, 3, instructionIndex width
- CHOSEN_W, $clog2(NUM_IN) (min 1), width of the chosen index

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- io_in_valid  in  NUM_IN  per-source request valid
- io_in_ready  out  NUM_IN  per-source accept
- io_in_bits_vs  in  NUM_IN*VS_W  packed, source i at [i*VS_W +: VS_W]
- io_in_bits_groupIndex  in  NUM_IN*GRP_W  packed likewise
- io_in_bits_readSource  in  NUM_IN*SRC_W  packed likewise
- io_in_bits_instructionIndex  in  NUM_IN*IDX_W  packed likewise
- io_out_ready  in  1  downstream accept
- io_out_valid  out  1  output register holds a request
- io_out_bits_vs / _groupIndex / _readSource / _instructionIndex  out  VS_W/GRP_W/SRC_W/IDX_W  registered payload
- io_out_bits_chosen  out  CHOSEN_W  source index of the held request
- perf_conflict_cnt  out  16  only with READ_ARB_PERF_EN

## Operation
- load_en = !io_out_valid | io_out_ready.
- Grant: the first valid source scanning from (ptr+1) mod NUM_IN upward with wrap. Grant depends only on io_in_valid and ptr, never on io_out_ready.
- io_in_ready[i] = grant[i] & load_en. At most one ready is high per cycle.
- Transfer occurs when any io_in_valid & io_in_ready. On transfer:
  - the output register loads the granted payload and chosen index;
  - io_out_valid is set;
  - ptr is set to the granted index.
- No transfer and io_out_ready high: io_out_valid clears; payload registers hold their value.
- ptr is unchanged in any cycle without a transfer. A stalled output therefore does not rotate priority.
- Simultaneous drain and refill (io_out_valid & io_out_ready & new transfer): the register is replaced and io_out_valid stays 1. No bubble.
- NUM_IN=1: ptr is omitted; io_in_ready[0] = load_en.

## Timing
- Reset values: io_out_valid=0, all payload and chosen outputs 0, ptr=NUM_IN-1 (so source 0 has first priority), perf counter 0.
- Latency: an input accepted in cycle t is presented at io_out in cycle t+1.
- Throughput: one request per cycle while io_out_ready is held high.
- Handshake:
  - io_out payload is stable while io_out_valid & !io_out_ready.
  - Inputs must hold valid and payload until ready. The arbiter may switch grant between cycles if a higher-priority source asserts valid.
- Reset mid-operation: the held request is dropped, io_out_valid falls asynchronously, and ptr returns to NUM_IN-1.
- No combinational path from io_in_* to io_out_*. There is a combinational path from io_out_ready to io_in_ready.

## Configuration
- READ_ARB_PERF_EN defined:
  - adds the 16-bit perf_conflict_cnt output;
  - increments it every cycle in which ≥2 io_in_valid bits are high;
  - saturates at 0xFFFF;
  - resets to 0.
- Undefined: the port and the counter logic are absent. Arbitration behaviour is identical in both builds.

## Structure
- Shared package read_arb_pkg:
  - read_req_t struct {vs, groupIndex, readSource, instructionIndex}, parameterised through localparam widths matching the defaults;
  - default width constants;
  - rr_next_grant function (one-hot grant from valid vector and ptr).
- One sub-module, rr_grant_comb: a purely combinational priority rotate that produces the one-hot grant and the binary chosen index.
- The top level contains the output register, ptr register and optional perf counter.

## Test plan
- Reset then single request: io_in_valid=4'b0100, vs=5'd9, io_out_ready=1. Then io_in_ready=4'b0100; next cycle io_out_valid=1, vs=9, chosen=2, ptr=2.
- Fairness: all four valid continuously, io_out_ready=1 from reset. Grant order is 0,1,2,3,0,… and io_out_bits_chosen follows it one cycle later.
- Backpressure: io_out held full with io_out_ready=0 for 5 cycles, all inputs valid. io_in_ready=0, payload and ptr unchanged. On release, the next grant is ptr+1.
- Drain and refill in the same cycle: io_out_valid=1, io_out_ready=1, source 3 valid with instructionIndex=3'd6. io_out_valid stays 1 and the next-cycle instructionIndex is 6 with no bubble.
- Asynchronous reset asserted mid-cycle while io_out_valid=1: io_out_valid falls before the next clock edge. After release, with sources 0 and 1 both valid, source 0 is granted first.
- READ_ARB_PERF_EN: 3 cycles with 2 sources valid and 1 cycle with 1 source valid give perf_conflict_cnt=3. Force the counter to 0xFFFE, then 3 conflict cycles give 0xFFFF.

Source files
------------

// File: rtl/read_stage_rr_arbiter_pipe_pkg.sv
// read_arb_pkg: shared widths, request struct and round-robin grant helper
// for read_stage_rr_arbiter_pipe (rev 1.0).
`default_nettype none

package read_arb_pkg;

  localparam int NUM_IN_DEF = 4;
  localparam int VS_W_DEF   = 5;
  localparam int GRP_W_DEF  = 4;
  localparam int SRC_W_DEF  = 4;
  localparam int IDX_W_DEF  = 3;
  localparam int MAX_IN     = 32;
  localparam int PTR_W_MAX  = 5;

  typedef struct packed {
    logic [VS_W_DEF-1:0]  vs;
    logic [GRP_W_DEF-1:0] groupIndex;
    logic [SRC_W_DEF-1:0] readSource;
    logic [IDX_W_DEF-1:0] instructionIndex;
  } read_req_t;

  // One-hot grant: first valid source at or after (ptr+1) mod n, wrapping.
  function automatic logic [MAX_IN-1:0] rr_next_grant(
    input logic [MAX_IN-1:0]    valid,
    input logic [PTR_W_MAX-1:0] ptr,
    input int                   n
  );
    logic [MAX_IN-1:0] grant;
    int                idx;
    grant = '0;
    for (int k = 1; k <= MAX_IN; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k <= n && grant == '0 && valid[idx[PTR_W_MAX-1:0]]) begin
        grant[idx[PTR_W_MAX-1:0]] = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

`default_nettype wire

// File: rtl/read_stage_rr_arbiter_pipe_if.sv
// read_stage_rr_arbiter_pipe_if: request fan-in and read-port channel.
// slave = arbiter side, master = sources/read-port side (rev 1.0).
`default_nettype none

interface read_stage_rr_arbiter_pipe_if
  import read_arb_pkg::*;
#(
  parameter int NUM_IN   = NUM_IN_DEF,
  parameter int VS_W     = VS_W_DEF,
  parameter int GRP_W    = GRP_W_DEF,
  parameter int SRC_W    = SRC_W_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int CHOSEN_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
);
  logic [NUM_IN-1:0]       io_in_valid;
  logic [NUM_IN-1:0]       io_in_ready;
  logic [NUM_IN*VS_W-1:0]  io_in_bits_vs;
  logic [NUM_IN*GRP_W-1:0] io_in_bits_groupIndex;
  logic [NUM_IN*SRC_W-1:0] io_in_bits_readSource;
  logic [NUM_IN*IDX_W-1:0] io_in_bits_instructionIndex;
  logic                    io_out_ready;
  logic                    io_out_valid;
  logic [VS_W-1:0]         io_out_bits_vs;
  logic [GRP_W-1:0]        io_out_bits_groupIndex;
  logic [SRC_W-1:0]        io_out_bits_readSource;
  logic [IDX_W-1:0]        io_out_bits_instructionIndex;
  logic [CHOSEN_W-1:0]     io_out_bits_chosen;

  modport slave (
    input  io_in_valid, io_in_bits_vs, io_in_bits_groupIndex,
           io_in_bits_readSource, io_in_bits_instructionIndex, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits_vs, io_out_bits_groupIndex,
           io_out_bits_readSource, io_out_bits_instructionIndex, io_out_bits_chosen
  );

  modport master (
    output io_in_valid, io_in_bits_vs, io_in_bits_groupIndex,
           io_in_bits_readSource, io_in_bits_instructionIndex, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits_vs, io_out_bits_groupIndex,
           io_out_bits_readSource, io_out_bits_instructionIndex, io_out_bits_chosen
  );

endinterface

`default_nettype wire

// File: rtl/read_stage_rr_arbiter_pipe_grant.sv
// rr_grant_comb: combinational rotate-priority grant (one-hot + binary index)
// for read_stage_rr_arbiter_pipe (rev 1.0).
`default_nettype none

module rr_grant_comb
  import read_arb_pkg::*;
#(
  parameter int NUM_IN   = 4,
  parameter int CHOSEN_W = 2
) (
  input  logic [NUM_IN-1:0]   valid,
  input  logic [CHOSEN_W-1:0] ptr,
  output logic [NUM_IN-1:0]   grant,
  output logic [CHOSEN_W-1:0] chosen
);

  logic [MAX_IN-1:0]    valid_ext;
  logic [MAX_IN-1:0]    grant_ext;
  logic [PTR_W_MAX-1:0] ptr_ext;
  logic                 unused_grant_bits;

  always_comb begin
    valid_ext                 = '0;
    valid_ext[NUM_IN-1:0]     = valid;
    ptr_ext                   = '0;
    ptr_ext[CHOSEN_W-1:0]     = ptr;
    grant_ext                 = rr_next_grant(valid_ext, ptr_ext, NUM_IN);
    grant                     = grant_ext[NUM_IN-1:0];
    chosen                    = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_ext[i]) chosen = i[CHOSEN_W-1:0];
    end
  end

  assign unused_grant_bits = ^grant_ext;

endmodule

`default_nettype wire

// File: rtl/read_stage_rr_arbiter_pipe.sv
// read_stage_rr_arbiter_pipe: N-way round-robin read-request merge with a registered
// output stage (rev 1.0). Optional READ_ARB_PERF_EN adds perf_conflict_cnt.
`default_nettype none

module read_stage_rr_arbiter_pipe
  import read_arb_pkg::*;
#(
  parameter int NUM_IN   = NUM_IN_DEF,
  parameter int VS_W     = VS_W_DEF,
  parameter int GRP_W    = GRP_W_DEF,
  parameter int SRC_W    = SRC_W_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int CHOSEN_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic clock,
  input  logic reset,
  read_stage_rr_arbiter_pipe_if.slave bus
`ifdef READ_ARB_PERF_EN
  ,
  output logic [15:0] perf_conflict_cnt
`endif
);

  logic                load_en;
  logic                xfer;
  logic [NUM_IN-1:0]   grant;
  logic [CHOSEN_W-1:0] grant_idx;

  logic                out_valid_q, out_valid_d;
  logic [VS_W-1:0]     vs_q, vs_d;
  logic [GRP_W-1:0]    grp_q, grp_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CHOSEN_W-1:0] chosen_q, chosen_d;

  assign load_en         = !out_valid_q || bus.io_out_ready;
  assign bus.io_in_ready = grant & {NUM_IN{load_en}};
  assign xfer            = |(bus.io_in_valid & bus.io_in_ready);

  generate
    if (NUM_IN > 1) begin : g_rr
      logic [CHOSEN_W-1:0] ptr_q, ptr_d;

      rr_grant_comb #(.NUM_IN(NUM_IN), .CHOSEN_W(CHOSEN_W)) u_grant (
        .valid  (bus.io_in_valid),
        .ptr    (ptr_q),
        .grant  (grant),
        .chosen (grant_idx)
      );

      // Priority only rotates on an accepted transfer, never on a stall.
      always_comb begin
        ptr_d = ptr_q;
        if (xfer) ptr_d = grant_idx;
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) ptr_q <= CHOSEN_W'(NUM_IN - 1);
        else        ptr_q <= ptr_d;
      end
    end else begin : g_single
      assign grant     = 1'b1;
      assign grant_idx = '0;
    end
  endgenerate

  always_comb begin
    out_valid_d = out_valid_q;
    vs_d        = vs_q;
    grp_d       = grp_q;
    src_d       = src_q;
    idx_d       = idx_q;
    chosen_d    = chosen_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      chosen_d    = grant_idx;
      for (int i = 0; i < NUM_IN; i++) begin
        if (grant[i]) begin
          vs_d  = bus.io_in_bits_vs[i*VS_W +: VS_W];
          grp_d = bus.io_in_bits_groupIndex[i*GRP_W +: GRP_W];
          src_d = bus.io_in_bits_readSource[i*SRC_W +: SRC_W];
          idx_d = bus.io_in_bits_instructionIndex[i*IDX_W +: IDX_W];
        end
      end
    end else if (bus.io_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      vs_q        <= '0;
      grp_q       <= '0;
      src_q       <= '0;
      idx_q       <= '0;
      chosen_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      vs_q        <= vs_d;
      grp_q       <= grp_d;
      src_q       <= src_d;
      idx_q       <= idx_d;
      chosen_q    <= chosen_d;
    end
  end

  assign bus.io_out_valid                 = out_valid_q;
  assign bus.io_out_bits_vs               = vs_q;
  assign bus.io_out_bits_groupIndex       = grp_q;
  assign bus.io_out_bits_readSource       = src_q;
  assign bus.io_out_bits_instructionIndex = idx_q;
  assign bus.io_out_bits_chosen           = chosen_q;

`ifdef READ_ARB_PERF_EN
  logic [15:0] perf_cnt_q, perf_cnt_d;
  logic        multi_valid;

  // v & (v-1) is nonzero exactly when two or more bits are set.
  always_comb begin
    multi_valid = |(bus.io_in_valid & (bus.io_in_valid - NUM_IN'(1)));
    perf_cnt_d  = perf_cnt_q;
    if (multi_valid && perf_cnt_q != 16'hFFFF) perf_cnt_d = perf_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) perf_cnt_q <= 16'd0;
    else        perf_cnt_q <= perf_cnt_d;
  end

  assign perf_conflict_cnt = perf_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_read_stage_rr_arbiter_pipe.sv
// tb_read_stage_rr_arbiter_pipe: vector table + scoreboard bench for the
// read-stage round-robin arbiter (rev 1.0).
`default_nettype none

module tb_read_stage_rr_arbiter_pipe;
  import read_arb_pkg::*;

  typedef struct packed {
    logic [3:0] v;
    logic       r;
    logic [3:0] exp_ready;
    logic       exp_ov;
    logic [1:0] exp_ch;
  } vec_t;

  typedef struct packed {
    read_req_t  req;
    logic [1:0] ch;
  } exp_t;

  localparam int NV = 27;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  read_stage_rr_arbiter_pipe_if #(.NUM_IN(4), .VS_W(5), .GRP_W(4), .SRC_W(4), .IDX_W(3)) bus ();

`ifdef READ_ARB_PERF_EN
  logic [15:0] perf_cnt;
`endif

  read_stage_rr_arbiter_pipe #(.NUM_IN(4), .VS_W(5), .GRP_W(4), .SRC_W(4), .IDX_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef READ_ARB_PERF_EN
    ,
    .perf_conflict_cnt (perf_cnt)
`endif
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  vec_t vecs[NV];
  exp_t exp_q[$];
  logic mv;
  int   mptr;
  int   seq[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  function automatic logic [3:0] m_grant(input logic [3:0] v, input int p);
    logic [3:0] g;
    logic [1:0] j;
    g = 4'b0;
    for (int k = 1; k <= 4; k++) begin
      j = 2'((p + k) % 4);
      if (g == 4'b0 && v[j]) g[j] = 1'b1;
    end
    return g;
  endfunction

  task automatic drive(input logic [3:0] v, input logic r);
    bus.io_in_valid  = v;
    bus.io_out_ready = r;
    for (int i = 0; i < 4; i++) begin
      bus.io_in_bits_vs[i*5 +: 5]               = 5'((i * 7 + seq[i] * 3 + 1) & 31);
      bus.io_in_bits_groupIndex[i*4 +: 4]       = 4'((i * 5 + seq[i]) & 15);
      bus.io_in_bits_readSource[i*4 +: 4]       = 4'((i + seq[i] * 9) & 15);
      bus.io_in_bits_instructionIndex[i*3 +: 3] = 3'((i * 3 + seq[i] * 5) & 7);
    end
  endtask

  // Reference model of the arbiter: held request, pointer, expected output.
  task automatic sample();
    logic [3:0] g;
    logic       load;
    exp_t       e;
    int         gi;
    if (!reset) begin
      mv   = 1'b0;
      mptr = 3;
      exp_q.delete();
      for (int i = 0; i < 4; i++) seq[i] = 0;
      chk("rst_out_valid", 32'(bus.io_out_valid), 32'(0));
      return;
    end
    chk("sb_out_valid", 32'(bus.io_out_valid), 32'(mv));
    if (mv && exp_q.size() > 0) begin
      e = exp_q[0];
      chk("sb_vs",     32'(bus.io_out_bits_vs),               32'(e.req.vs));
      chk("sb_grp",    32'(bus.io_out_bits_groupIndex),       32'(e.req.groupIndex));
      chk("sb_src",    32'(bus.io_out_bits_readSource),       32'(e.req.readSource));
      chk("sb_idx",    32'(bus.io_out_bits_instructionIndex), 32'(e.req.instructionIndex));
      chk("sb_chosen", 32'(bus.io_out_bits_chosen),           32'(e.ch));
    end
    load = !mv || bus.io_out_ready;
    g    = load ? m_grant(bus.io_in_valid, mptr) : 4'b0;
    chk("sb_in_ready", 32'(bus.io_in_ready), 32'(g));
    gi = -1;
    for (int k = 0; k < 4; k++) if (g[k]) gi = k;
    if (gi >= 0) begin
      if (mv && exp_q.size() > 0) void'(exp_q.pop_front());
      e.req.vs               = bus.io_in_bits_vs[gi*5 +: 5];
      e.req.groupIndex       = bus.io_in_bits_groupIndex[gi*4 +: 4];
      e.req.readSource       = bus.io_in_bits_readSource[gi*4 +: 4];
      e.req.instructionIndex = bus.io_in_bits_instructionIndex[gi*3 +: 3];
      e.ch                   = 2'(gi);
      exp_q.push_back(e);
      mptr    = gi;
      mv      = 1'b1;
      seq[gi] = seq[gi] + 1;
    end else if (bus.io_out_ready) begin
      if (mv && exp_q.size() > 0) void'(exp_q.pop_front());
      mv = 1'b0;
    end
  endtask

  task automatic step(input logic [3:0] v, input logic r);
    @(posedge clock);
    #1;
    drive(v, r);
    @(negedge clock);
    sample();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    drive(4'b0, 1'b0);
    repeat (2) begin
      @(negedge clock);
      sample();
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //                v        r     ready    ov    ch
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
    vecs[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[10] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    vecs[11] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1};
    vecs[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[13] = '{4'b1001, 1'b1, 4'b1000, 1'b0, 2'd0};
    vecs[14] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3};
    vecs[15] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[16] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd0};
    vecs[17] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd1};
    vecs[18] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2};
    vecs[19] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd2};
    vecs[20] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd2};
    vecs[21] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
    vecs[22] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
    vecs[23] = '{4'b0100, 1'b0, 4'b0100, 1'b0, 2'd0};
    vecs[24] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2};
    vecs[25] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2};
    vecs[26] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

    mv   = 1'b0;
    mptr = 3;
    for (int i = 0; i < 4; i++) seq[i] = 0;
    drive(4'b0, 1'b0);
    #2;
    apply_reset();

    chk("reset_ov",     32'(bus.io_out_valid), 32'(0));
    chk("reset_vs",     32'(bus.io_out_bits_vs), 32'(0));
    chk("reset_grp",    32'(bus.io_out_bits_groupIndex), 32'(0));
    chk("reset_src",    32'(bus.io_out_bits_readSource), 32'(0));
    chk("reset_idx",    32'(bus.io_out_bits_instructionIndex), 32'(0));
    chk("reset_chosen", 32'(bus.io_out_bits_chosen), 32'(0));

    // Fairness, backpressure, wrap/skip and empty-register loading.
    for (int k = 0; k < NV; k++) begin
      step(vecs[k].v, vecs[k].r);
      chk($sformatf("vec%0d_ready", k), 32'(bus.io_in_ready), 32'(vecs[k].exp_ready));
      chk($sformatf("vec%0d_ovalid", k), 32'(bus.io_out_valid), 32'(vecs[k].exp_ov));
      if (vecs[k].exp_ov) begin
        chk($sformatf("vec%0d_chosen", k), 32'(bus.io_out_bits_chosen), 32'(vecs[k].exp_ch));
      end
    end

    // Single request from source 2 right after reset.
    apply_reset();
    @(posedge clock);
    #1;
    drive(4'b0100, 1'b1);
    bus.io_in_bits_vs[10 +: 5] = 5'd9;
    @(negedge clock);
    sample();
    chk("single_ready", 32'(bus.io_in_ready), 32'(4'b0100));
    step(4'b1001, 1'b1);
    chk("single_ov",     32'(bus.io_out_valid), 32'(1));
    chk("single_vs",     32'(bus.io_out_bits_vs), 32'(9));
    chk("single_chosen", 32'(bus.io_out_bits_chosen), 32'(2));
    chk("single_ptr2",   32'(bus.io_in_ready), 32'(4'b1000));
    step(4'b0001, 1'b1);
    chk("wrap_ready", 32'(bus.io_in_ready), 32'(4'b0001));

    // Drain and refill in the same cycle.
    @(posedge clock);
    #1;
    drive(4'b1000, 1'b1);
    bus.io_in_bits_instructionIndex[9 +: 3] = 3'd6;
    @(negedge clock);
    sample();
    chk("refill_ov",    32'(bus.io_out_valid), 32'(1));
    chk("refill_ready", 32'(bus.io_in_ready), 32'(4'b1000));
    step(4'b0000, 1'b0);
    chk("refill_ov_next", 32'(bus.io_out_valid), 32'(1));
    chk("refill_idx",     32'(bus.io_out_bits_instructionIndex), 32'(6));
    chk("refill_chosen",  32'(bus.io_out_bits_chosen), 32'(3));

    // Asynchronous reset in the middle of a cycle with a held request.
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("async_ov",  32'(bus.io_out_valid), 32'(0));
    chk("async_idx", 32'(bus.io_out_bits_instructionIndex), 32'(0));
    drive(4'b0011, 1'b1);
    @(negedge clock);
    sample();
    @(posedge clock);
    #1;
    reset = 1'b1;
    drive(4'b0011, 1'b1);
    @(negedge clock);
    sample();
    chk("post_rst_ready", 32'(bus.io_in_ready), 32'(4'b0001));
    step(4'b0010, 1'b1);
    chk("post_rst_chosen", 32'(bus.io_out_bits_chosen), 32'(0));
    chk("post_rst_ready1", 32'(bus.io_in_ready), 32'(4'b0010));
    step(4'b0000, 1'b1);
    chk("post_rst_chosen1", 32'(bus.io_out_bits_chosen), 32'(1));

`ifdef READ_ARB_PERF_EN
    apply_reset();
    chk("perf_reset", 32'(perf_cnt), 32'(0));
    repeat (3) step(4'b0011, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    chk("perf_three", 32'(perf_cnt), 32'(3));
    repeat (65531) step(4'b0011, 1'b1);
    step(4'b0000, 1'b1);
    chk("perf_fffe", 32'(perf_cnt), 32'(16'hFFFE));
    repeat (3) step(4'b0011, 1'b1);
    step(4'b0000, 1'b1);
    chk("perf_sat", 32'(perf_cnt), 32'(16'hFFFF));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
